// File: rtl/noc_link_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_pipeline
// Brief    : Registered router-to-router NoC link. Retimes flit and credit
//            paths by NUM_PIPELINE stages, keeps saturating flit/packet
//            statistics, and builds the credit checker when
//            NOC_LINK_CREDIT_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module noc_link_pipeline #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] flit_count,
    output logic [STAT_WIDTH-1:0] pkt_count,
    output logic                  err_credit_underflow,
    output logic                  err_credit_overflow
);

    localparam int c_FWD_W = FLIT_WIDTH + DEST_WIDTH + 2;

    logic [c_FWD_W-1:0] w_fwd_in;
    logic [c_FWD_W-1:0] w_fwd_out;
    logic               w_credit_out;

    assign w_fwd_in = {send_in, is_tail_in, dest_in, data_in};

    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign w_fwd_out    = w_fwd_in;
            assign w_credit_out = credit_in;
        end else begin : g_stages
            logic [c_FWD_W-1:0]      r_fwd [NUM_PIPELINE];
            logic [NUM_PIPELINE-1:0] r_cred;

            // Free-running shift: every stage reloads every cycle, no stall.
            always_ff @(posedge clk_noc) begin
                if (rst_noc_sync) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) begin
                        r_fwd[i] <= '0;
                    end
                    r_cred <= '0;
                end else begin
                    r_fwd[0]  <= w_fwd_in;
                    r_cred[0] <= credit_in;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        r_fwd[i]  <= r_fwd[i-1];
                        r_cred[i] <= r_cred[i-1];
                    end
                end
            end

            assign w_fwd_out    = r_fwd[NUM_PIPELINE-1];
            assign w_credit_out = r_cred[NUM_PIPELINE-1];
        end
    endgenerate

    assign {send_out, is_tail_out, dest_out, data_out} = w_fwd_out;
    assign credit_out = w_credit_out;

    logic [STAT_WIDTH-1:0] r_flit_cnt;
    logic [STAT_WIDTH-1:0] r_pkt_cnt;

    // Clear has priority over increment; counters stick at all-ones.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync || stat_clr) begin
            r_flit_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (send_out && (r_flit_cnt != {STAT_WIDTH{1'b1}})) begin
                r_flit_cnt <= r_flit_cnt + STAT_WIDTH'(1);
            end
            if (send_out && is_tail_out && (r_pkt_cnt != {STAT_WIDTH{1'b1}})) begin
                r_pkt_cnt <= r_pkt_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign flit_count = r_flit_cnt;
    assign pkt_count  = r_pkt_cnt;

`ifdef NOC_LINK_CREDIT_CHECK_EN
    localparam int                c_CR_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [c_CR_W-1:0] c_CR_MAX = c_CR_W'(FLIT_BUFFER_DEPTH);

    logic [c_CR_W-1:0] r_cr;
    logic              r_err_uf;
    logic              r_err_of;

    // Send and credit in the same cycle cancel out and are never an error.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_cr     <= c_CR_MAX;
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
        end else if (send_in && !w_credit_out) begin
            if (r_cr == '0) begin
                r_err_uf <= 1'b1;
            end else begin
                r_cr <= r_cr - c_CR_W'(1);
            end
        end else if (w_credit_out && !send_in) begin
            if (r_cr == c_CR_MAX) begin
                r_err_of <= 1'b1;
            end else begin
                r_cr <= r_cr + c_CR_W'(1);
            end
        end
    end

    assign err_credit_underflow = r_err_uf;
    assign err_credit_overflow  = r_err_of;
`else
    assign err_credit_underflow = 1'b0;
    assign err_credit_overflow  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_link_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_link_pipeline
// Brief    : Self-checking bench for noc_link_pipeline; a 2-stage/4-bit-stat
//            instance and a 0-stage instance share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_link_pipeline;

    localparam int FW    = 32;
    localparam int DW    = 6;
    localparam int DEPTH = 8;
`ifdef NOC_LINK_CREDIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, send_in, is_tail_in, credit_in, stat_clr;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;

    logic          a_credit_out, a_send_out, a_tail_out, a_uf, a_of;
    logic [FW-1:0] a_data_out;
    logic [DW-1:0] a_dest_out;
    logic [3:0]    a_fc, a_pc;

    logic          b_credit_out, b_send_out, b_tail_out, b_uf, b_of;
    logic [FW-1:0] b_data_out;
    logic [DW-1:0] b_dest_out;
    logic [15:0]   b_fc, b_pc;

    noc_link_pipeline #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2),
                        .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(4)) u_dut_a (
        .clk_noc(clk), .rst_noc_sync(rst), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(a_credit_out),
        .data_out(a_data_out), .dest_out(a_dest_out), .is_tail_out(a_tail_out),
        .send_out(a_send_out), .credit_in(credit_in), .stat_clr(stat_clr),
        .flit_count(a_fc), .pkt_count(a_pc),
        .err_credit_underflow(a_uf), .err_credit_overflow(a_of));

    noc_link_pipeline #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
                        .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(16)) u_dut_b (
        .clk_noc(clk), .rst_noc_sync(rst), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(b_credit_out),
        .data_out(b_data_out), .dest_out(b_dest_out), .is_tail_out(b_tail_out),
        .send_out(b_send_out), .credit_in(credit_in), .stat_clr(stat_clr),
        .flit_count(b_fc), .pkt_count(b_pc),
        .err_credit_underflow(b_uf), .err_credit_overflow(b_of));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: input history + counters ----------------
    typedef struct packed {
        logic          send;
        logic          tail;
        logic [DW-1:0] dest;
        logic [FW-1:0] data;
        logic          cred;
    } smp_t;

    smp_t hist[$];
    int   cyc      = -1;
    int   last_rst = -1;
    bit   started  = 1'b0;
    int   m_fc[2], m_pc[2], m_cr[2];
    bit   m_uf[2], m_of[2];

    // Output at cycle t is the input of cycle t-np, or zero if that input
    // was not newer than the most recent reset.
    function automatic smp_t expect_out(input int np);
        if (np == 0) return hist[cyc];
        if (cyc - np > last_rst) return hist[cyc - np];
        return '0;
    endfunction

    task automatic check_dut(input int i, input logic s, input logic t,
                             input logic [DW-1:0] d, input logic [FW-1:0] dat,
                             input logic cr, input logic [63:0] fc,
                             input logic [63:0] pc, input logic uf, input logic of);
        smp_t  e;
        string p;
        int    smax;
        e    = expect_out(i == 0 ? 2 : 0);
        p    = (i == 0) ? "np2" : "np0";
        smax = (i == 0) ? 15 : 65535;
        chk({p, ".send_out"},    s,   e.send);
        chk({p, ".is_tail_out"}, t,   e.tail);
        chk({p, ".dest_out"},    d,   e.dest);
        chk({p, ".data_out"},    dat, e.data);
        chk({p, ".credit_out"},  cr,  e.cred);
        chk({p, ".flit_count"},  fc,  m_fc[i]);
        chk({p, ".pkt_count"},   pc,  m_pc[i]);
        chk({p, ".err_uf"},      uf,  CHK & m_uf[i]);
        chk({p, ".err_of"},      of,  CHK & m_of[i]);
        if (hist[cyc].send == 1'b0 && stat_clr) begin
            m_fc[i] = 0;
            m_pc[i] = 0;
        end else if (stat_clr) begin
            m_fc[i] = 0;
            m_pc[i] = 0;
        end else begin
            if (e.send && m_fc[i] < smax) m_fc[i]++;
            if (e.send && e.tail && m_pc[i] < smax) m_pc[i]++;
        end
        if (hist[cyc].send && !e.cred) begin
            if (m_cr[i] == 0) m_uf[i] = 1'b1; else m_cr[i]--;
        end else if (e.cred && !hist[cyc].send) begin
            if (m_cr[i] == DEPTH) m_of[i] = 1'b1; else m_cr[i]++;
        end
    endtask

    always @(negedge clk) begin
        smp_t s;
        s.send = send_in; s.tail = is_tail_in; s.dest = dest_in;
        s.data = data_in; s.cred = credit_in;
        hist.push_back(s);
        cyc++;
        if (rst) begin
            started  = 1'b1;
            last_rst = cyc;
            for (int i = 0; i < 2; i++) begin
                m_fc[i] = 0; m_pc[i] = 0; m_cr[i] = DEPTH;
                m_uf[i] = 1'b0; m_of[i] = 1'b0;
            end
        end else if (started) begin
            check_dut(0, a_send_out, a_tail_out, a_dest_out, a_data_out,
                      a_credit_out, a_fc, a_pc, a_uf, a_of);
            check_dut(1, b_send_out, b_tail_out, b_dest_out, b_data_out,
                      b_credit_out, b_fc, b_pc, b_uf, b_of);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic t, input logic [DW-1:0] d,
                         input logic [FW-1:0] dat, input logic cr,
                         input logic clr, input logic r);
        @(posedge clk);
        #1;
        send_in = s; is_tail_in = t; dest_in = d; data_in = dat;
        credit_in = cr; stat_clr = clr; rst = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic          send;
        logic          tail;
        logic [DW-1:0] dest;
        logic [FW-1:0] data;
        logic          x_send;
        logic          x_tail;
        logic [DW-1:0] x_dest;
        logic [FW-1:0] x_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst = 1'b1; send_in = 1'b0; is_tail_in = 1'b0; credit_in = 1'b0;
        stat_clr = 1'b0; data_in = '0; dest_in = '0;

        // 4-flit packet through the 2-stage link: outputs lag inputs by 2
        vecs[0] = '{1'b1, 1'b0, 6'h05, 32'hA0, 1'b0, 1'b0, 6'h00, 32'h00};
        vecs[1] = '{1'b1, 1'b0, 6'h05, 32'hA1, 1'b0, 1'b0, 6'h00, 32'h00};
        vecs[2] = '{1'b1, 1'b0, 6'h05, 32'hA2, 1'b1, 1'b0, 6'h05, 32'hA0};
        vecs[3] = '{1'b1, 1'b1, 6'h05, 32'hA3, 1'b1, 1'b0, 6'h05, 32'hA1};
        vecs[4] = '{1'b0, 1'b0, 6'h00, 32'h00, 1'b1, 1'b0, 6'h05, 32'hA2};
        vecs[5] = '{1'b0, 1'b0, 6'h00, 32'h00, 1'b1, 1'b1, 6'h05, 32'hA3};

        repeat (3) do_reset();
        idle();
        @(negedge clk);
        chk("rst.a_send_out", a_send_out, 0);
        chk("rst.a_data_out", a_data_out, 0);
        chk("rst.a_credit_out", a_credit_out, 0);
        chk("rst.a_flit_count", a_fc, 0);
        chk("rst.a_err", {a_uf, a_of, b_uf, b_of}, 0);

        for (int k = 0; k < 6; k++) begin
            drive(vecs[k].send, vecs[k].tail, vecs[k].dest, vecs[k].data, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("pkt[%0d].send", k), a_send_out, vecs[k].x_send);
            chk($sformatf("pkt[%0d].tail", k), a_tail_out, vecs[k].x_tail);
            chk($sformatf("pkt[%0d].dest", k), a_dest_out, vecs[k].x_dest);
            chk($sformatf("pkt[%0d].data", k), a_data_out, vecs[k].x_data);
        end
        idle();
        @(negedge clk);
        chk("pkt.flit_count", a_fc, 4);
        chk("pkt.pkt_count", a_pc, 1);

        // zero-stage link is combinational in both directions
        drive(1'b1, 1'b0, 6'h03, 32'h1234, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("np0.credit_same_cycle", b_credit_out, 1);
        chk("np0.flit_same_cycle", {b_send_out, b_data_out}, {1'b1, 32'h1234});
        chk("np2.credit_not_yet", a_credit_out, 0);
        idle();

        // underflow: 9 flits against 8 credits
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 6'h01, 32'(k), 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (k > 0) chk($sformatf("uf.early[%0d]", k), a_uf, 0);
        end
        idle();
        @(negedge clk);
        chk("uf.np2_flag", a_uf, CHK);
        chk("uf.np0_flag", b_uf, CHK);
        chk("uf.no_overflow", {a_of, b_of}, 0);

        // overflow: a single credit with the counter already full
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("of.np0_flag", b_of, CHK);
        idle();
        @(negedge clk);
        chk("of.np2_not_yet", a_of, 0);
        idle();
        @(negedge clk);
        chk("of.np2_flag", a_of, CHK);
        do_reset();
        idle();
        @(negedge clk);
        chk("of.rst_flags", {a_uf, a_of, b_uf, b_of}, 0);
        chk("of.rst_outputs", {a_send_out, a_tail_out, a_credit_out, a_dest_out, a_data_out}, 0);

        // saturation of the 4-bit counters and clear-beats-increment
        do_reset();
        for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 6'h02, 32'(k), 1'b0, 1'b0, 1'b0);
        repeat (3) idle();
        @(negedge clk);
        chk("sat.np2_flit_count", a_fc, 15);
        chk("sat.np0_flit_count", b_fc, 16);
        drive(1'b1, 1'b1, 6'h02, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("clr.tail_arriving", {a_send_out, a_tail_out}, 2'b11);
        idle();
        @(negedge clk);
        chk("clr.np2_counts", {a_fc, a_pc}, 0);
        chk("clr.np0_counts", {b_fc, b_pc}, 0);

        // reset with two flits in flight
        drive(1'b1, 1'b0, 6'h07, 32'hC0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 6'h07, 32'hC1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            @(negedge clk);
            chk($sformatf("midrst.send_out[%0d]", k), {a_send_out, a_data_out}, 0);
        end

        // random traffic checked by the reference model
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
                  $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
        end
        repeat (4) idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_link_pipeline.md
# noc_link_pipeline

Registered router-to-router link stage for the NoC. It sits directly downstream of one router's output port (`data_out`/`dest_out`/`is_tail_out`/`send_out`/`credit_in`) and upstream of the neighbouring router's input port. It retimes the forward flit path and the reverse credit path by a configurable number of register stages, so long inter-router wires can close timing. It also keeps flit and packet statistics and can optionally check the credit protocol.

## Interface
Parameters:
- `FLIT_WIDTH`, 32: flit payload width.
- `DEST_WIDTH`, 6: destination field width (TDEST + TID).
- `NUM_PIPELINE`, 2: register stages on each direction; legal range 0..8.
- `FLIT_BUFFER_DEPTH`, 8: input buffer depth of the receiving router. This is the initial credit count used by the checker.
- `STAT_WIDTH`, 32: width of each statistics counter.

Ports:
- `clk_noc`  in  1: NoC clock. One clock; the block has no other clock.
- `rst_noc_sync`  in  1: synchronous, active-high reset.
- `data_in`  in  FLIT_WIDTH: flit from the upstream router.
- `dest_in`  in  DEST_WIDTH: destination from the upstream router.
- `is_tail_in`  in  1: last flit of the packet.
- `send_in`  in  1: flit valid.
- `credit_out`  out  1: credit returned to the upstream router.
- `data_out`  out  FLIT_WIDTH: flit to the downstream router.
- `dest_out`  out  DEST_WIDTH: destination to the downstream router.
- `is_tail_out`  out  1: tail flag to the downstream router.
- `send_out`  out  1: flit valid to the downstream router.
- `credit_in`  in  1: credit from the downstream router.
- `stat_clr`  in  1: synchronous clear of both statistics counters.
- `flit_count`  out  STAT_WIDTH: flits delivered on `send_out`.
- `pkt_count`  out  STAT_WIDTH: tails delivered, i.e. `send_out & is_tail_out`.
- `err_credit_underflow`  out  1: sticky flag; a flit was sent with no credit available.
- `err_credit_overflow`  out  1: sticky flag; more credits returned than the buffer depth allows.

## Operation
- Forward path: `{send, is_tail, dest, data}` passes through NUM_PIPELINE register stages. Each stage loads its input every cycle; there is no stall and no backpressure, so flow control is purely credit-based.
- Reverse path: `credit_in` passes through NUM_PIPELINE single-bit register stages to `credit_out`.
- NUM_PIPELINE = 0: both paths are pure wires with zero latency. Statistics and the checker are still present.
- The link never drops, duplicates or reorders flits or credits.
- Credit round trip seen by the upstream router grows by 2·NUM_PIPELINE cycles. Full-rate throughput requires FLIT_BUFFER_DEPTH ≥ router round trip + 2·NUM_PIPELINE; this is a system constraint and is not enforced here.
- Statistics counters:
  - `flit_count` increments by 1 on each cycle with `send_out`=1.
  - `pkt_count` increments by 1 on each cycle with `send_out & is_tail_out`.
  - Both saturate at all-ones; there is no wrap-around.
  - `stat_clr` sets both counters to 0 on the next edge. Clear wins over a simultaneous increment, so the result is 0.
- Credit checker, sampled at the upstream-facing ports:
  - Counter `cr`, width $clog2(FLIT_BUFFER_DEPTH+1), loads FLIT_BUFFER_DEPTH at reset.
  - Next value is `cr - send_in + credit_out`. If both occur in the same cycle, the count is unchanged and no error is raised.
  - Underflow: `cr`==0, `send_in`=1, `credit_out`=0. Sets `err_credit_underflow`; `cr` holds at 0.
  - Overflow: `cr`==FLIT_BUFFER_DEPTH, `credit_out`=1, `send_in`=0. Sets `err_credit_overflow`; `cr` holds at FLIT_BUFFER_DEPTH.
  - Error flags are sticky until `rst_noc_sync`. `stat_clr` does not affect the checker.

## Timing
- Forward latency: `send_out`/`data_out`/`dest_out`/`is_tail_out` at cycle t+NUM_PIPELINE equal the inputs at cycle t.
- Credit latency: `credit_out` at cycle t+NUM_PIPELINE equals `credit_in` at cycle t.
- Statistics counters update one cycle after the qualifying `send_out` cycle.
- Error flags assert one cycle after the offending input cycle.
- Throughput: one flit and one credit per cycle, sustained indefinitely.
- Reset values: all stage registers 0, so `send_out`, `credit_out`, `data_out`, `dest_out` and `is_tail_out` are all 0. Counters are 0, error flags are 0, and `cr` is FLIT_BUFFER_DEPTH.
- Reset mid-operation: flits and credits in flight are discarded. Both attached routers must be reset in the same cycle; the link makes no attempt to recover partial packets.

## Configuration
- `NOC_LINK_CREDIT_CHECK_EN` defined: the credit counter and both sticky error flags are built as described under Operation.
- `NOC_LINK_CREDIT_CHECK_EN` undefined:
  - No checker logic is instantiated.
  - `err_credit_underflow` and `err_credit_overflow` are tied to 0.
  - The ports remain, so the interface is identical in both builds.
  - Pipeline and statistics behaviour is unchanged.

## Test plan
- NUM_PIPELINE=2: drive a 4-flit packet (data 0xA0..0xA3, dest 0x05, tail on the last flit) back-to-back starting at cycle 10. Expect identical flits on cycles 12..15, then `flit_count`=4 and `pkt_count`=1.
- NUM_PIPELINE=0: pulse `credit_in` at cycle 5. Expect `credit_out`=1 in the same cycle (5) and a flit passed through combinationally.
- Checker built, FLIT_BUFFER_DEPTH=8, no credits returned: send 9 flits. Expect `err_credit_underflow`=1 one cycle after the 9th flit, and `err_credit_overflow`=0.
- Checker built: after reset, pulse `credit_in` once and wait NUM_PIPELINE cycles. Expect `err_credit_overflow`=1. Assert `rst_noc_sync` for 1 cycle; expect both flags 0 and all outputs 0.
- Force `flit_count` near all-ones (STAT_WIDTH=4, 16 flits sent). Expect it to hold at 0xF. Assert `stat_clr` in the same cycle as a tail flit arrives on `send_out`; expect both counters 0 the next cycle.
- Reset mid-packet: assert reset with 2 flits in flight (NUM_PIPELINE=2). Expect no `send_out` pulses afterwards and all stages cleared.
